// File: rtl/reset_requester.sv
// reset_requester: turns a debounced reset button, a software strobe and a
// watchdog expiry into a fixed-length active-low reset request. It also
// records the cause of the last request and how many requests were issued.
module reset_requester #(
    parameter int DEBOUNCE_CYCLES = 16,
    parameter int HOLD_CYCLES     = 8
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        button_n,
    input  logic        sw_reset_strobe,
    input  logic        wdt_kick,
    input  logic [15:0] wdt_timeout,
    output logic        reset_req,
    output logic [1:0]  reset_cause,
    output logic [7:0]  reset_count
);

    localparam int DB_W = $clog2(DEBOUNCE_CYCLES + 1);
    localparam int HD_W = $clog2(HOLD_CYCLES + 1);
    // The count holds the number of qualifying samples already seen, so the
    // sample that completes the run arrives while the count is at N-1.
    localparam logic [DB_W-1:0] DB_LAST = DB_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [HD_W-1:0] HD_LAST = HD_W'(HOLD_CYCLES - 1);

    typedef enum logic [1:0] {
        LOCKOUT  = 2'd0,
        IDLE     = 2'd1,
        DEBOUNCE = 2'd2,
        ASSERT   = 2'd3
    } state_t;

    state_t            state_q;
    logic [1:0]        sync_q;
    logic [DB_W-1:0]   db_cnt_q;
    logic [HD_W-1:0]   hold_q;
    logic              req_q;
    logic [15:0]       wdt_q;
    logic [1:0]        cause_q;
    logic [7:0]        count_q;

    logic              btn;
    logic              wdt_expire;
    logic              btn_fire;
    logic              fire;
    logic [1:0]        cause_d;

    assign btn = sync_q[1];

    // A kick on the expiry edge wins, so it masks the expiry.
    assign wdt_expire = (wdt_timeout != 16'd0) && (wdt_q == wdt_timeout) && !wdt_kick;

    // Button fires on the sample that completes a full low run.
    always_comb begin
        btn_fire = 1'b0;
        case (state_q)
            IDLE:     btn_fire = !btn && (DEBOUNCE_CYCLES == 1);
            DEBOUNCE: btn_fire = !btn && (db_cnt_q == DB_LAST);
            default:  btn_fire = 1'b0;
        endcase
    end

    // Triggers are only honoured outside the hold; priority watchdog > software > button.
    always_comb begin
        fire    = (state_q != ASSERT) && (wdt_expire || sw_reset_strobe || btn_fire);
        cause_d = 2'b01;
        if (wdt_expire) begin
            cause_d = 2'b11;
        end else if (sw_reset_strobe) begin
            cause_d = 2'b10;
        end
    end

    // Two-flop synchronizer for the asynchronous button; idles released.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            sync_q <= 2'b11;
        end else begin
            sync_q <= {sync_q[0], button_n};
        end
    end

    // Watchdog counter: saturating, cleared by kick, by disable and on request.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            wdt_q <= 16'd0;
        end else if ((wdt_timeout == 16'd0) || wdt_kick || fire) begin
            wdt_q <= 16'd0;
        end else if (wdt_q != 16'hFFFF) begin
            wdt_q <= wdt_q + 16'd1;
        end
    end

    // Cause and saturating request count update once per request.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            cause_q <= 2'b00;
            count_q <= 8'd0;
        end else if (fire) begin
            cause_q <= cause_d;
            if (count_q != 8'hFF) begin
                count_q <= count_q + 8'd1;
            end
        end
    end

    // Main FSM: lockout until the button is seen released, debounce presses,
    // and hold the registered request low for the hold period.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q  <= LOCKOUT;
            db_cnt_q <= '0;
            hold_q   <= '0;
            req_q    <= 1'b1;
        end else if (fire) begin
            state_q  <= ASSERT;
            db_cnt_q <= '0;
            hold_q   <= '0;
            req_q    <= 1'b0;
        end else begin
            case (state_q)
                LOCKOUT: begin
                    if (btn) begin
                        if (db_cnt_q == DB_LAST) begin
                            state_q  <= IDLE;
                            db_cnt_q <= '0;
                        end else begin
                            db_cnt_q <= db_cnt_q + DB_W'(1);
                        end
                    end else begin
                        db_cnt_q <= '0;
                    end
                end
                IDLE: begin
                    if (!btn) begin
                        state_q  <= DEBOUNCE;
                        db_cnt_q <= DB_W'(1);
                    end
                end
                DEBOUNCE: begin
                    if (btn) begin
                        state_q  <= IDLE;
                        db_cnt_q <= '0;
                    end else begin
                        db_cnt_q <= db_cnt_q + DB_W'(1);
                    end
                end
                ASSERT: begin
                    if (hold_q == HD_LAST) begin
                        req_q   <= 1'b1;
                        hold_q  <= '0;
                        // A button request must see a release before re-arming.
                        state_q <= (cause_q == 2'b01) ? LOCKOUT : IDLE;
                    end else begin
                        hold_q <= hold_q + HD_W'(1);
                    end
                end
                default: begin
                    state_q <= LOCKOUT;
                    req_q   <= 1'b1;
                end
            endcase
        end
    end

    assign reset_req   = req_q;
    assign reset_cause = cause_q;
    assign reset_count = count_q;

endmodule

// File: tb/tb_reset_requester.sv
// Scoreboard bench for reset_requester with default parameters.
module tb_reset_requester;

    logic        clk = 1'b0;
    logic        reset_n;
    logic        button_n;
    logic        sw_reset_strobe;
    logic        wdt_kick;
    logic [15:0] wdt_timeout;
    logic        reset_req;
    logic [1:0]  reset_cause;
    logic [7:0]  reset_count;

    reset_requester dut (
        .clk             (clk),
        .reset_n         (reset_n),
        .button_n        (button_n),
        .sw_reset_strobe (sw_reset_strobe),
        .wdt_kick        (wdt_kick),
        .wdt_timeout     (wdt_timeout),
        .reset_req       (reset_req),
        .reset_cause     (reset_cause),
        .reset_count     (reset_count)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc++;

    localparam int HOLD = 8;

    typedef struct {
        int         start;
        logic [1:0] cause;
        logic [7:0] count;
    } exp_t;

    exp_t q[$];
    int   checks   = 0;
    int   failures = 0;
    int   n_req    = 0;
    int   n_push   = 0;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic expect_req(input int start, input logic [1:0] cause, input logic [7:0] count);
        exp_t e;
        e.start = start;
        e.cause = cause;
        e.count = count;
        q.push_back(e);
        n_push++;
    endtask

    task automatic wait_cycles(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic pulse_sw();
        sw_reset_strobe = 1'b1;
        wait_cycles(1);
        sw_reset_strobe = 1'b0;
    endtask

    task automatic pulse_kick();
        wdt_kick = 1'b1;
        wait_cycles(1);
        wdt_kick = 1'b0;
    endtask

    // Monitor: a falling reset_req is a presented request; pop and compare.
    logic prev_req = 1'b1;
    logic in_hold  = 1'b0;
    int   width    = 0;
    always @(negedge clk) begin
        if (!reset_n) begin
            in_hold  = 1'b0;
            prev_req = reset_req;
        end else begin
            if (prev_req && !reset_req) begin
                n_req++;
                if (q.size() == 0) begin
                    checks++;
                    failures++;
                    $display("FAIL unexpected_req: request at cycle %0d, none expected", cyc);
                end else begin
                    exp_t e;
                    e = q.pop_front();
                    chk("req_start", cyc, e.start);
                    chk("req_cause", int'(reset_cause), int'(e.cause));
                    chk("req_count", int'(reset_count), int'(e.count));
                end
                in_hold = 1'b1;
                width   = 1;
            end else if (in_hold && !reset_req) begin
                width++;
            end else if (in_hold && reset_req) begin
                chk("hold_width", width, HOLD);
                in_hold = 1'b0;
            end
            prev_req = reset_req;
        end
    end

    initial begin
        reset_n         = 1'b0;
        button_n        = 1'b0;
        sw_reset_strobe = 1'b0;
        wdt_kick        = 1'b0;
        wdt_timeout     = 16'd0;

        // Reset state with the button already held low.
        wait_cycles(3);
        chk("rst_req", int'(reset_req), 1);
        chk("rst_cause", int'(reset_cause), 0);
        chk("rst_count", int'(reset_count), 0);
        reset_n = 1'b1;

        // Button held from reset: locked out until released then pressed.
        wait_cycles(30);
        button_n = 1'b1;
        wait_cycles(40);
        button_n = 1'b0;
        expect_req(cyc + 18, 2'b01, 8'd1);
        wait_cycles(30);
        button_n = 1'b1;
        wait_cycles(40);

        // Glitch shorter than the debounce: no request, back to idle.
        button_n = 1'b0;
        wait_cycles(10);
        button_n = 1'b1;
        wait_cycles(10);
        chk("glitch_req_high", int'(reset_req), 1);
        button_n = 1'b0;
        expect_req(cyc + 18, 2'b01, 8'd2);
        wait_cycles(20);
        button_n = 1'b1;
        wait_cycles(40);

        // Software strobe; a second strobe during the hold is dropped.
        expect_req(cyc + 1, 2'b10, 8'd3);
        pulse_sw();
        wait_cycles(2);
        pulse_sw();
        wait_cycles(20);

        // Watchdog expiry, T=100.
        wdt_timeout = 16'd100;
        expect_req(cyc + 102, 2'b11, 8'd4);
        pulse_kick();
        wait_cycles(120);

        // Kick landing on the expiry edge suppresses the request.
        pulse_kick();
        wait_cycles(100);
        pulse_kick();
        wdt_timeout = 16'd0;
        wait_cycles(20);
        chk("kick_wins_count", int'(reset_count), 4);

        // Watchdog expiry and software strobe on the same edge.
        wdt_timeout = 16'd100;
        expect_req(cyc + 102, 2'b11, 8'd5);
        pulse_kick();
        wait_cycles(100);
        pulse_sw();
        wdt_timeout = 16'd0;
        wait_cycles(20);

        // reset_n asserted during the third hold cycle.
        expect_req(cyc + 1, 2'b10, 8'd6);
        pulse_sw();
        wait_cycles(2);
        #2;
        reset_n = 1'b0;
        #1;
        chk("abort_req", int'(reset_req), 1);
        chk("abort_cause", int'(reset_cause), 0);
        chk("abort_count", int'(reset_count), 0);
        wait_cycles(2);
        reset_n = 1'b1;

        // Lockout after reset: an immediate press must not fire.
        button_n = 1'b0;
        wait_cycles(30);
        button_n = 1'b1;
        wait_cycles(40);
        chk("lockout_count", int'(reset_count), 0);

        // Count restarts at 1 and saturates at 255.
        for (int k = 1; k <= 257; k++) begin
            expect_req(cyc + 1, 2'b10, (k > 255) ? 8'd255 : 8'(k));
            pulse_sw();
            wait_cycles(9);
        end
        wait_cycles(20);
        chk("sat_count", int'(reset_count), 255);

        chk("req_total", n_req, n_push);
        chk("queue_empty", q.size(), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/reset_requester.md
RESET_REQUESTER -- requirements
Module: reset_requester

Interface
REQ-001 SHALL have parameter DEBOUNCE_CYCLES, default 16: consecutive stable synchronized button samples required to accept a press or a release.
REQ-002 SHALL have parameter HOLD_CYCLES, default 8: clk cycles reset_req is held low per request.
REQ-003 SHALL have port clk  input  1  single system clock; all logic on its rising edge.
REQ-004 SHALL have port reset_n  input  1  asynchronous, active-low reset; driven by power-on/PLL-lock reset, never by the downstream system reset.
REQ-005 SHALL have port button_n  input  1  external reset button, active-low, asynchronous to clk.
REQ-006 SHALL have port sw_reset_strobe  input  1  one-cycle software reset request.
REQ-007 SHALL have port wdt_kick  input  1  one-cycle watchdog service pulse.
REQ-008 SHALL have port wdt_timeout  input  16  watchdog period in clk cycles; 0 disables the watchdog.
REQ-009 SHALL have port reset_req  output  1  active-low reset request to the reset controller; 0 = reset requested.
REQ-010 SHALL have port reset_cause  output  2  cause of last request: 00 none, 01 button, 10 software, 11 watchdog.
REQ-011 SHALL have port reset_count  output  8  number of requests issued, saturating at 255.

Function
REQ-012 SHALL synchronize button_n through two flip-flops before any use; no other logic samples button_n.
REQ-013 SHALL implement states LOCKOUT, IDLE, DEBOUNCE, ASSERT.
REQ-014 LOCKOUT: count consecutive high synchronized samples, clear count on any low sample, go to IDLE when count reaches DEBOUNCE_CYCLES.
REQ-015 IDLE: a low synchronized sample moves to DEBOUNCE with count 1.
REQ-016 DEBOUNCE: a high sample returns to IDLE; DEBOUNCE_CYCLES consecutive low samples moves to ASSERT with cause 01.
REQ-017 In LOCKOUT, IDLE and DEBOUNCE, sw_reset_strobe high moves to ASSERT with cause 10, abandoning any debounce in progress.
REQ-018 In LOCKOUT, IDLE and DEBOUNCE, watchdog expiry moves to ASSERT with cause 11.
REQ-019 Simultaneous triggers SHALL resolve with priority watchdog > software > button; only one request is issued.
REQ-020 ASSERT: reset_req SHALL be 0 for exactly HOLD_CYCLES cycles, then the state goes to LOCKOUT if cause is 01, otherwise to IDLE.
REQ-021 All triggers arriving during ASSERT SHALL be ignored, not queued.
REQ-022 reset_req SHALL be registered and be 1 in every state except ASSERT.
REQ-023 Software latency: reset_req is 0 after the edge that samples sw_reset_strobe high.
REQ-024 Button latency: reset_req is 0 after the (DEBOUNCE_CYCLES+2)-th edge sampling button_n low, counting the first such edge as 1.
REQ-025 The watchdog counter SHALL be 16 bits, held at 0 while wdt_timeout is 0, cleared by wdt_kick, cleared on ASSERT entry, and otherwise incremented each cycle without wrap.
REQ-026 Watchdog expiry occurs when counter equals wdt_timeout (nonzero): reset_req is 0 after the (T+1)-th edge following the edge sampling wdt_kick.
REQ-027 wdt_kick coincident with expiry SHALL win: no request is issued and the counter clears.
REQ-028 reset_cause SHALL load on ASSERT entry and hold until the next ASSERT entry.
REQ-029 reset_count SHALL increment on ASSERT entry and saturate at 255.

Reset
REQ-030 reset_n low SHALL immediately force: state LOCKOUT, reset_req 1, reset_cause 00, reset_count 0, watchdog counter 0, debounce count 0, synchronizer flops 1.
REQ-031 Assertion of reset_n mid-ASSERT SHALL abort the hold; reset_req returns to 1 asynchronously.
REQ-032 After reset_n deasserts, a button held low SHALL NOT produce a request until it is seen released for DEBOUNCE_CYCLES cycles and then pressed again.

Verification
REQ-033 Button low from reset release, then released 40 cycles, then pressed (defaults) -> no request until release; reset_req low 18 edges after the press for 8 cycles; cause 01; count 1.
REQ-034 Button glitch low for 10 cycles in IDLE -> reset_req stays 1; state returns to IDLE.
REQ-035 sw_reset_strobe pulse in IDLE -> reset_req low the next cycle for 8 cycles; cause 10; second strobe during hold ignored; count 1.
REQ-036 wdt_timeout=100 with kick, then none -> reset_req low 101 edges after the kick; cause 11; kick at cycle 100 instead -> no request.
REQ-037 Watchdog expiry and sw_reset_strobe on the same edge -> a single request with cause 11.
REQ-038 reset_n asserted during cycle 3 of a hold -> reset_req 1 immediately; cause 00; count 0; FSM in LOCKOUT.
